// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data accesses.
// Data wins by default. A starvation counter forces a fetch grant after STARVE_LIMIT back-to-back data wins.
module mem_port_arbiter #(
  parameter int unsigned MEM_LATENCY  = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        halted,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_data_in  [0:3],
  input  logic [7:0]  mem_data_out [0:3],
  output logic        mem_write_en,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  localparam logic [3:0] LAT_LOAD   = 4'(MEM_LATENCY - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic [3:0]  lat_q, lat_d;
  logic [3:0]  starve_q, starve_d;
  logic        owner_data_q, owner_data_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        if_ack_q, if_ack_d;
  logic        d_ack_q, d_ack_d;
  logic        wen_q, wen_d;
  logic        busy_q, busy_d;
  logic        grant_data;
  logic [31:0] mem_word;

  assign mem_word = {mem_data_out[3], mem_data_out[2], mem_data_out[1], mem_data_out[0]};

  always_comb begin
    state_d      = state_q;
    lat_d        = lat_q;
    starve_d     = starve_q;
    owner_data_d = owner_data_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    if_ack_d     = 1'b0;
    d_ack_d      = 1'b0;
    wen_d        = 1'b0;
    grant_data   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!halted && (if_req || d_req)) begin
          grant_data   = d_req && !(if_req && (starve_q == STARVE_MAX));
          owner_data_d = grant_data;
          addr_d       = grant_data ? d_addr : if_addr;
          we_d         = grant_data && d_we;
          wen_d        = grant_data && d_we;
          if (grant_data) wdata_d = d_wdata;
          lat_d        = LAT_LOAD;
          state_d      = BUSY;
          // Only a data win over a waiting fetch counts toward starvation.
          if (grant_data && if_req)
            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 4'd1;
          else
            starve_d = '0;
        end
      end
      BUSY: begin
        if (lat_q == '0) begin
          state_d = RESP;
          if (owner_data_q) begin
            d_ack_d = 1'b1;
            if (!we_q) d_rdata_d = mem_word;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_word;
          end
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state_q      <= IDLE;
      lat_q        <= '0;
      starve_q     <= '0;
      owner_data_q <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      wen_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_q        <= lat_d;
      starve_q     <= starve_d;
      owner_data_q <= owner_data_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      if_ack_q     <= if_ack_d;
      d_ack_q      <= d_ack_d;
      wen_q        <= wen_d;
      busy_q       <= busy_d;
    end
  end

  assign if_ack         = if_ack_q;
  assign d_ack          = d_ack_q;
  assign if_rdata       = if_rdata_q;
  assign d_rdata        = d_rdata_q;
  assign mem_addr       = addr_q;
  assign mem_write_en   = wen_q;
  assign busy           = busy_q;
  assign mem_data_in[0] = wdata_q[7:0];
  assign mem_data_in[1] = wdata_q[15:8];
  assign mem_data_in[2] = wdata_q[23:16];
  assign mem_data_in[3] = wdata_q[31:24];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed checks of mem_port_arbiter against an edge-indexed transaction model.
module tb_mem_port_arbiter;

  localparam int unsigned LAT  = 2;
  localparam int unsigned SLIM = 4;

  logic        clk = 1'b0;
  logic        rst_b, halted;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        if_ack, d_ack, mem_write_en, busy;
  logic [31:0] if_rdata, d_rdata, mem_addr;
  logic [7:0]  mem_data_in  [0:3];
  logic [7:0]  mem_data_out [0:3];
  logic [31:0] mem_word_tb, din_word;

  int n_checks = 0;
  int n_errors = 0;

  // Model: each grant at edge g owns the port through edge g+LAT (ack), next grant no earlier than g+LAT+2.
  int          e = 0;
  int          g = -1000;
  int          free_edge = 0;
  int          starve = 0;
  bit          g_data, g_we;
  logic [31:0] g_addr, g_wdata;
  logic [31:0] exp_ird = '0;
  logic [31:0] exp_drd = '0;
  bit          exp_iack, exp_dack;
  int          ack_log[$];
  int          ack_edge[$];

  mem_port_arbiter #(.MEM_LATENCY(LAT), .STARVE_LIMIT(SLIM)) dut (
    .clk(clk), .rst_b(rst_b), .halted(halted),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .mem_write_en(mem_write_en), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (a == 32'h100) return 32'h2402000A;
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  assign mem_word_tb     = memval(mem_addr);
  assign mem_data_out[0] = mem_word_tb[7:0];
  assign mem_data_out[1] = mem_word_tb[15:8];
  assign mem_data_out[2] = mem_word_tb[23:16];
  assign mem_data_out[3] = mem_word_tb[31:24];
  assign din_word        = {mem_data_in[3], mem_data_in[2], mem_data_in[1], mem_data_in[0]};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    g         = -1000;
    free_edge = 0;
    starve    = 0;
    exp_ird   = '0;
    exp_drd   = '0;
  endtask

  task automatic step();
    bit own_d;
    @(posedge clk);
    e++;
    if (rst_b) begin
      model_reset();
    end else if (e >= free_edge && !halted && (if_req || d_req)) begin
      own_d = d_req && !(if_req && starve == int'(SLIM));
      if (own_d && if_req) starve = (starve < int'(SLIM)) ? starve + 1 : starve;
      else starve = 0;
      g         = e;
      g_data    = own_d;
      g_we      = own_d && d_we;
      g_addr    = own_d ? d_addr : if_addr;
      g_wdata   = d_wdata;
      free_edge = e + int'(LAT) + 2;
    end
    #1;
    exp_iack = !rst_b && (e == g + int'(LAT)) && !g_data;
    exp_dack = !rst_b && (e == g + int'(LAT)) && g_data;
    if (exp_iack) exp_ird = memval(g_addr);
    if (exp_dack && !g_we) exp_drd = memval(g_addr);
    if (if_ack) begin ack_log.push_back(1); ack_edge.push_back(e); end
    if (d_ack)  begin ack_log.push_back(0); ack_edge.push_back(e); end
    check_eq("busy", busy, !rst_b && e >= g && e <= g + int'(LAT));
    check_eq("if_ack", if_ack, exp_iack);
    check_eq("d_ack", d_ack, exp_dack);
    check_eq("wen", mem_write_en, !rst_b && e == g && g_we);
    check_eq("if_rdata", if_rdata, exp_ird);
    check_eq("d_rdata", d_rdata, exp_drd);
    if (!rst_b && e >= g && e < g + int'(LAT)) begin
      check_eq("mem_addr", mem_addr, g_addr);
      if (g_we) check_eq("mem_data_in", din_word, g_wdata);
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      if (exp_iack) if_req = 1'b0;
      if (exp_dack) d_req = 1'b0;
    end
  endtask

  task automatic pulse_reset();
    rst_b = 1'b1;
    model_reset();
    #1;
    check_eq("rst_busy", busy, 0);
    step();
    rst_b = 1'b0;
  endtask

  initial begin
    int t0, got_edge, acks, wen_cnt;
    rst_b = 1'b1; halted = 1'b0;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    #2;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_if_ack", if_ack, 0);
    check_eq("rst_d_ack", d_ack, 0);
    check_eq("rst_wen", mem_write_en, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_if_rdata", if_rdata, 0);
    check_eq("rst_d_rdata", d_rdata, 0);
    check_eq("rst_mem_data_in", din_word, 0);
    step(); step();
    rst_b = 1'b0;

    // Single fetch
    if_req = 1'b1; if_addr = 32'h100;
    t0 = e + 1; got_edge = -1; acks = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (if_ack) begin if (got_edge < 0) got_edge = e; acks++; end
      if (exp_iack) if_req = 1'b0;
    end
    check_eq("fetch_latency", got_edge - t0, LAT);
    check_eq("fetch_ack_cycles", acks, 1);
    check_eq("fetch_data", if_rdata, 32'h2402000A);

    // Store
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hA1B2C3D4;
    step();
    check_eq("store_wen", mem_write_en, 1);
    check_eq("store_addr", mem_addr, 32'h40);
    check_eq("store_lane0", mem_data_in[0], 8'hD4);
    check_eq("store_lane3", mem_data_in[3], 8'hA1);
    wen_cnt = 1; acks = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (mem_write_en) wen_cnt++;
      if (d_ack) acks++;
      if (exp_dack) d_req = 1'b0;
    end
    check_eq("store_wen_cycles", wen_cnt, 1);
    check_eq("store_ack_cycles", acks, 1);
    d_we = 1'b0;

    // Simultaneous requests
    ack_log.delete(); ack_edge.delete();
    if_req = 1'b1; if_addr = 32'h200; d_req = 1'b1; d_addr = 32'h300;
    drain(12);
    check_eq("simul_ack_count", ack_log.size(), 2);
    if (ack_log.size() >= 2) begin
      check_eq("simul_first_data", ack_log[0], 0);
      check_eq("simul_second_fetch", ack_log[1], 1);
      check_eq("simul_gap", ack_edge[1] - ack_edge[0], LAT + 2);
    end

    // Starvation with both requests held continuously
    pulse_reset();
    ack_log.delete(); ack_edge.delete();
    if_req = 1'b1; if_addr = 32'h180; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h280;
    for (int i = 0; i < 80 && ack_log.size() < 6; i++) step();
    check_eq("starve_ack_count", ack_log.size() >= 6, 1);
    if (ack_log.size() >= 6) begin
      for (int i = 0; i < 6; i++) check_eq("starve_order", ack_log[i], (i == 4) ? 1 : 0);
    end
    if_req = 1'b0; d_req = 1'b0;
    drain(6);

    // Halted blocks grants in IDLE
    halted = 1'b1; if_req = 1'b1; if_addr = 32'h500;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("halt_no_grant", busy, 0);
    end
    halted = 1'b0;
    step();
    check_eq("halt_release_grant", busy, 1);
    drain(6);

    // Reset during BUSY of a load
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
    step();
    check_eq("ld_busy", busy, 1);
    #2;
    rst_b = 1'b1;
    model_reset();
    #1;
    check_eq("async_rst_busy", busy, 0);
    check_eq("async_rst_d_ack", d_ack, 0);
    check_eq("async_rst_mem_addr", mem_addr, 0);
    d_req = 1'b0;
    step(); step();
    rst_b = 1'b0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin step(); if (d_ack) acks++; end
    check_eq("aborted_no_ack", acks, 0);
    d_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (d_ack) acks++;
      if (exp_dack) d_req = 1'b0;
    end
    check_eq("rereq_ack", acks, 1);
    check_eq("rereq_data", d_rdata, memval(32'h600));

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step();
      if (exp_iack) if_req = 1'b0;
      else if (!if_req && $urandom_range(3) == 0) begin
        if_req = 1'b1; if_addr = $urandom() & 32'hFFFF_FFFC;
      end
      if (exp_dack) d_req = 1'b0;
      else if (!d_req && $urandom_range(2) == 0) begin
        d_req = 1'b1; d_we = $urandom_range(1) == 1;
        d_addr = $urandom() & 32'hFFFF_FFFC; d_wdata = $urandom();
      end
      if ($urandom_range(15) == 0) halted = !halted;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
